// File: rtl/y86_mem_responder.sv
// y86_mem_responder: memory-side bus responder for the y86 sequential core.
// Byte-addressed RAM with combinational unaligned 32-bit little-endian reads,
// synchronous unaligned 32-bit writes, a byte-stream program loader, access
// counters and sticky error flags.
// Optional feature macro: MEM_WRITE_PROTECT_EN (drops RUN writes that touch
// any byte address below PROTECT_LIMIT).
module y86_mem_responder #(
    parameter int ADDR_BITS     = 10,
    parameter int PROTECT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_A,
    output logic [31:0] bus_in,
    input  logic [31:0] bus_out,
    input  logic        bus_WE,
    input  logic        bus_RE,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    input  logic        load_done,
    output logic        running,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        oob_err,
    output logic        conflict_err
);

    localparam int MEM_BYTES = 1 << ADDR_BITS;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [ADDR_BITS:0]     load_ptr;
    logic [7:0]             mem [MEM_BYTES];

    // Byte lanes of the current access; addresses wrap within the RAM.
    logic [ADDR_BITS-1:0]   byte_addr [4];
    logic                   addr_oob;
    logic                   rd_acc;
    logic                   wr_acc;
    logic                   wr_protected;
    logic                   wr_commit;
    logic                   load_acc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_addr[gi] = bus_A[ADDR_BITS-1:0] + ADDR_BITS'(gi);
        end
    endgenerate

    assign addr_oob = |bus_A[31:ADDR_BITS];
    assign rd_acc   = (state == RUN) && bus_RE;
    assign wr_acc   = (state == RUN) && bus_WE;

`ifdef MEM_WRITE_PROTECT_EN
    // A write is protected if any of its four (wrapped) target bytes is low.
    logic [3:0] prot_hit;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_prot
            assign prot_hit[gi] = {{(32-ADDR_BITS){1'b0}}, byte_addr[gi]} < 32'(PROTECT_LIMIT);
        end
    endgenerate
    assign wr_protected = |prot_hit;
`else
    assign wr_protected = 1'b0;
`endif

    assign wr_commit  = wr_acc && !addr_oob && !wr_protected;
    assign load_ready = (state == LOAD) && !load_ptr[ADDR_BITS];
    assign load_acc   = load_valid && load_ready;
    assign running    = (state == RUN);

    // Zero-latency read path; returns pre-write contents during a same-cycle write.
    always_comb begin
        bus_in = 32'h0;
        if (rd_acc && !addr_oob) begin
            bus_in = {mem[byte_addr[3]], mem[byte_addr[2]],
                      mem[byte_addr[1]], mem[byte_addr[0]]};
        end
    end

    // RAM write port: loader bytes in LOAD, 4-byte unaligned bus writes in RUN.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            mem[load_ptr[ADDR_BITS-1:0]] <= load_data;
        end else if (wr_commit) begin
            for (int k = 0; k < 4; k++) begin
                mem[byte_addr[k]] <= bus_out[8*k +: 8];
            end
        end
    end

    // Control FSM, loader pointer, counters and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            load_ptr     <= '0;
            rd_count     <= 32'h0;
            wr_count     <= 32'h0;
            oob_err      <= 1'b0;
            conflict_err <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_acc) begin
                        load_ptr <= load_ptr + 1'b1;
                    end
                    if (load_valid && load_ptr[ADDR_BITS]) begin
                        oob_err <= 1'b1;
                    end
                    if (load_done) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rd_acc) begin
                        rd_count <= rd_count + 32'd1;
                    end
                    if (wr_acc) begin
                        wr_count <= wr_count + 32'd1;
                    end
                    if (((rd_acc || wr_acc) && addr_oob) || (wr_acc && wr_protected)) begin
                        oob_err <= 1'b1;
                    end
                    if (rd_acc && wr_acc) begin
                        conflict_err <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_mem_responder.sv
// Testbench for y86_mem_responder: directed and randomized bus/loader traffic
// checked against a byte-array reference model of the memory and its counters.
module tb_y86_mem_responder;

    localparam int AB = 10;
    localparam int MB = 1 << AB;
`ifdef MEM_WRITE_PROTECT_EN
    localparam int PLIM = 16;
`else
    localparam int PLIM = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] bus_A;
    logic [31:0] bus_in;
    logic [31:0] bus_out;
    logic        bus_WE;
    logic        bus_RE;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        load_done;
    logic        running;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic        oob_err;
    logic        conflict_err;

    y86_mem_responder #(.ADDR_BITS(AB), .PROTECT_LIMIT(PLIM)) dut (
        .clk(clk), .rst_n(rst_n), .bus_A(bus_A), .bus_in(bus_in),
        .bus_out(bus_out), .bus_WE(bus_WE), .bus_RE(bus_RE),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .load_done(load_done), .running(running), .rd_count(rd_count),
        .wr_count(wr_count), .oob_err(oob_err), .conflict_err(conflict_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m [MB];
    int unsigned ptr;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    logic        exp_oob;
    logic        exp_conf;
    int          compared;
    int          mismatched;
    logic [31:0] rdata;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a >= MB) return 32'h0;
        return {m[(a + 3) % MB], m[(a + 2) % MB], m[(a + 1) % MB], m[a]};
    endfunction

    function automatic bit model_protected(input logic [31:0] a);
        for (int k = 0; k < 4; k++) begin
            if (((a + k) % MB) < PLIM) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".rd_count"}, rd_count, exp_rd);
        chk({tag, ".wr_count"}, wr_count, exp_wr);
        chk({tag, ".oob_err"}, {31'h0, oob_err}, {31'h0, exp_oob});
        chk({tag, ".conflict_err"}, {31'h0, conflict_err}, {31'h0, exp_conf});
    endtask

    // One RUN-state bus cycle; entered shortly after a rising edge.
    task automatic bus_op(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input string tag, output logic [31:0] obs);
        logic [31:0] exp;
        bus_WE = we; bus_RE = re; bus_A = a; bus_out = d;
        #1;
        exp = re ? model_read(a) : 32'h0;
        obs = bus_in;
        chk({tag, ".bus_in"}, bus_in, exp);
        if (re) begin
            exp_rd++;
            if (a >= MB) exp_oob = 1'b1;
        end
        if (we) begin
            exp_wr++;
            if (a >= MB || model_protected(a)) exp_oob = 1'b1;
            else for (int k = 0; k < 4; k++) m[(a + k) % MB] = d[8*k +: 8];
        end
        if (we && re) exp_conf = 1'b1;
        @(posedge clk); #1;
        bus_WE = 1'b0; bus_RE = 1'b0;
        chk_status(tag);
        $display("bus %s we=%0b re=%0b A=%h wdata=%h rdata=%h", tag, we, re, a, d, obs);
    endtask

    task automatic load_byte(input logic [7:0] d, input logic done);
        load_valid = 1'b1; load_data = d; load_done = done;
        if (ptr < MB) begin
            m[ptr] = d;
            ptr++;
        end else begin
            exp_oob = 1'b1;
        end
        @(posedge clk); #1;
        load_valid = 1'b0; load_done = 1'b0;
    endtask

    task automatic model_reset();
        ptr = 0; exp_rd = 0; exp_wr = 0; exp_oob = 1'b0; exp_conf = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic        we;
        logic        re;
        compared = 0; mismatched = 0;
        rst_n = 1'b0; bus_A = 32'h0; bus_out = 32'h0; bus_WE = 1'b0; bus_RE = 1'b0;
        load_valid = 1'b0; load_data = 8'h0; load_done = 1'b0;
        model_reset();
        #12;
        chk("reset.running", {31'h0, running}, 32'h0);
        chk("reset.load_ready", {31'h0, load_ready}, 32'h1);
        chk("reset.bus_in", bus_in, 32'h0);
        chk_status("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill the whole RAM while bus strobes toggle randomly (must be ignored in LOAD).
        for (int i = 0; i < MB; i++) begin
            bus_RE = 1'b1; bus_WE = 1'($urandom);
            bus_A = $urandom_range(0, MB - 1); bus_out = $urandom;
            #1;
            chk("load.bus_in", bus_in, 32'h0);
            load_byte(8'($urandom), 1'b0);
        end
        bus_RE = 1'b0; bus_WE = 1'b0;
        chk("full.load_ready", {31'h0, load_ready}, 32'h0);
        chk_status("full");
        load_byte(8'hAA, 1'b0);
        chk_status("overflow");
        chk("overflow.running", {31'h0, running}, 32'h0);
        load_byte(8'hBB, 1'b1);
        chk("run1.running", {31'h0, running}, 32'h1);
        chk("run1.load_ready", {31'h0, load_ready}, 32'h0);
        for (int i = 0; i < 20; i++) bus_op(1'b0, 1'b1, $urandom_range(0, MB - 1), 32'h0, "scan", rdata);

        // Asynchronous reset mid-RUN.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset.running", {31'h0, running}, 32'h0);
        chk("areset.load_ready", {31'h0, load_ready}, 32'h1);
        chk_status("areset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed program load: bytes 01..08, end-of-image with the last byte.
        for (int i = 1; i <= 7; i++) load_byte(8'(i), 1'b0);
        load_byte(8'h08, 1'b1);
        chk("prog.running", {31'h0, running}, 32'h1);
        bus_op(1'b0, 1'b1, 32'd0, 32'h0, "rd0", rdata);
        chk("rd0.literal", rdata, 32'h04030201);
`ifdef MEM_WRITE_PROTECT_EN
        bus_op(1'b1, 1'b0, 32'd14, 32'hCAFEF00D, "prot14", rdata);
        bus_op(1'b0, 1'b1, 32'd14, 32'h0, "prot14rd", rdata);
        bus_op(1'b1, 1'b0, 32'd16, 32'h5A5AA5A5, "prot16", rdata);
        bus_op(1'b0, 1'b1, 32'd16, 32'h0, "prot16rd", rdata);
        chk("prot16.literal", rdata, 32'h5A5AA5A5);
`endif
        bus_op(1'b1, 1'b0, 32'd4, 32'hDEADBEEF, "wr4", rdata);
        bus_op(1'b0, 1'b1, 32'd3, 32'h0, "rd3", rdata);
`ifndef MEM_WRITE_PROTECT_EN
        chk("rd3.literal", rdata, 32'hADBEEF04);
`endif
        bus_op(1'b1, 1'b0, 32'd1022, 32'h11223344, "wrwrap", rdata);
        bus_op(1'b0, 1'b1, 32'd1022, 32'h0, "rdwrap", rdata);
        bus_op(1'b0, 1'b1, 32'd0, 32'h0, "rdwrap0", rdata);
`ifndef MEM_WRITE_PROTECT_EN
        chk("rdwrap.literal", rdata[15:0], 32'h1122);
`endif
        bus_op(1'b0, 1'b1, 32'd1024, 32'h0, "rdoob", rdata);
        bus_op(1'b1, 1'b0, 32'h8000_0000, 32'h12345678, "wroob", rdata);
        bus_op(1'b1, 1'b1, 32'd100, 32'h87654321, "conflict", rdata);
        bus_op(1'b0, 1'b1, 32'd100, 32'h0, "postconf", rdata);
        chk("postconf.literal", rdata, 32'h87654321);

        // Randomized traffic, biased toward the wrap boundary and out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0:       a = $urandom_range(MB - 3, MB - 1);
                1:       a = $urandom_range(MB, 32'hFFFF_FFFF);
                default: a = $urandom_range(0, MB - 1);
            endcase
            we = 1'($urandom); re = 1'($urandom);
            bus_op(we, re, a, $urandom, "rand", rdata);
        end

        // Reset preserves RAM: read back after a bare load_done.
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        load_done = 1'b1;
        @(posedge clk); #1;
        load_done = 1'b0;
        chk("rerun.running", {31'h0, running}, 32'h1);
        for (int i = 0; i < 20; i++) bus_op(1'b0, 1'b1, $urandom_range(0, MB - 1), 32'h0, "keep", rdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
